// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory master for loads/stores, load alignment/extension, branch resolve, MEM/WB register.
// Memory ops take >= 2 cycles with o_stall high until ack; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage #(
  parameter int NB_PC   = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               MEM_reg_write,
  input  logic               MEM_mem_to_reg,
  input  logic               MEM_mem_read,
  input  logic               MEM_mem_write,
  input  logic               MEM_branch,
  input  logic               MEM_zero,
  input  logic               MEM_byte_en,
  input  logic               MEM_halfword_en,
  input  logic               MEM_word_en,
  input  logic               MEM_r31_ctrl,
  input  logic               MEM_unsigned,
  input  logic [NB_PC-1:0]   MEM_branch_addr,
  input  logic [NB_DATA-1:0] MEM_alu_result,
  input  logic [NB_DATA-1:0] MEM_data_a,
  input  logic [NB_REG-1:0]  MEM_selected_reg,
  input  logic [NB_PC-1:0]   MEM_pc,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [NB_ADDR-1:0] o_dmem_addr,
  output logic [3:0]         o_dmem_be,
  output logic [NB_DATA-1:0] o_dmem_wdata,
  input  logic               i_dmem_ack,
  input  logic [NB_DATA-1:0] i_dmem_rdata,
  output logic               o_stall,
  output logic               o_pc_src,
  output logic [NB_PC-1:0]   o_branch_addr,
  output logic               WB_reg_write,
  output logic               WB_mem_to_reg,
  output logic               WB_r31_ctrl,
  output logic [NB_DATA-1:0] WB_read_data,
  output logic [NB_DATA-1:0] WB_alu_result,
  output logic [NB_REG-1:0]  WB_selected_reg,
  output logic [NB_PC-1:0]   WB_pc,
  output logic               o_misalign
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  state_t             state_q, state_d;
  size_t              size;
  logic               access, is_store, is_load;
  logic               misalign, trap, ack_done, stall;
  logic [1:0]         offset;
  logic [NB_ADDR-1:0] eff_addr;

  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [3:0]         be_q, be_d, lane_be;
  logic [NB_DATA-1:0] wdata_q, wdata_d, lane_wdata;

  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic               ext_bit;
  logic [NB_DATA-1:0] load_data;

  logic               wb_reg_write_q, wb_mem_to_reg_q, wb_r31_ctrl_q;
  logic [NB_DATA-1:0] wb_read_data_q, wb_read_data_d, wb_alu_result_q;
  logic [NB_REG-1:0]  wb_selected_reg_q;
  logic [NB_PC-1:0]   wb_pc_q;

  assign access   = MEM_mem_read | MEM_mem_write;
  assign is_store = MEM_mem_write;
  assign is_load  = MEM_mem_read & ~MEM_mem_write;
  assign offset   = MEM_alu_result[1:0];
  assign eff_addr = NB_ADDR'(MEM_alu_result);

  always_comb begin
    size = SZ_WORD;
    if (MEM_word_en)          size = SZ_WORD;
    else if (MEM_halfword_en) size = SZ_HALF;
    else if (MEM_byte_en)     size = SZ_BYTE;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (((size == SZ_HALF) & offset[0]) |
                              ((size == SZ_WORD) & (offset != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // A trapped access never leaves IDLE, so the check only matters there.
  assign trap     = (state_q == ST_IDLE) & misalign;
  assign ack_done = (state_q == ST_WAIT) & i_dmem_ack;
  assign stall    = i_reset & access & ~trap & ~ack_done;

  assign o_stall       = stall;
  assign o_pc_src      = MEM_branch & MEM_zero;
  assign o_branch_addr = MEM_branch_addr;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = MEM_data_a;
    case (size)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << offset;
        lane_wdata = {4{MEM_data_a[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = offset[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{MEM_data_a[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access & ~trap) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = eff_addr & ~NB_ADDR'(3);
          be_d    = lane_be;
          wdata_d = lane_wdata;
        end
      end
      ST_WAIT: begin
        if (i_dmem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;

  // The EX/MEM register is frozen during WAIT, so offset/size still describe the pending load.
  assign rd_byte = i_dmem_rdata[{offset, 3'b000} +: 8];
  assign rd_half = offset[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    ext_bit   = 1'b0;
    load_data = i_dmem_rdata;
    case (size)
      SZ_BYTE: begin
        ext_bit   = ~MEM_unsigned & rd_byte[7];
        load_data = {{(NB_DATA-8){ext_bit}}, rd_byte};
      end
      SZ_HALF: begin
        ext_bit   = ~MEM_unsigned & rd_half[15];
        load_data = {{(NB_DATA-16){ext_bit}}, rd_half};
      end
      default: ;
    endcase
  end

  assign wb_read_data_d = (is_load & ack_done) ? load_data : '0;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wb_reg_write_q    <= 1'b0;
      wb_mem_to_reg_q   <= 1'b0;
      wb_r31_ctrl_q     <= 1'b0;
      wb_read_data_q    <= '0;
      wb_alu_result_q   <= '0;
      wb_selected_reg_q <= '0;
      wb_pc_q           <= '0;
    end else if (stall) begin
      wb_reg_write_q    <= 1'b0;
    end else begin
      wb_reg_write_q    <= MEM_reg_write & ~trap;
      wb_mem_to_reg_q   <= MEM_mem_to_reg;
      wb_r31_ctrl_q     <= MEM_r31_ctrl;
      wb_read_data_q    <= wb_read_data_d;
      wb_alu_result_q   <= MEM_alu_result;
      wb_selected_reg_q <= MEM_selected_reg;
      wb_pc_q           <= MEM_pc;
    end
  end

  assign WB_reg_write    = wb_reg_write_q;
  assign WB_mem_to_reg   = wb_mem_to_reg_q;
  assign WB_r31_ctrl     = wb_r31_ctrl_q;
  assign WB_read_data    = wb_read_data_q;
  assign WB_alu_result   = wb_alu_result_q;
  assign WB_selected_reg = wb_selected_reg_q;
  assign WB_pc           = wb_pc_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) misalign_q <= 1'b0;
    else          misalign_q <= trap;
  end
  assign o_misalign = misalign_q;
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: per-instruction reference model driving per-cycle expectations, plus directed literal cases.
module tb_mem_access_stage;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch, MEM_zero;
  logic        MEM_byte_en, MEM_halfword_en, MEM_word_en, MEM_r31_ctrl, MEM_unsigned;
  logic [31:0] MEM_branch_addr, MEM_alu_result, MEM_data_a, MEM_pc;
  logic [4:0]  MEM_selected_reg;
  logic        o_dmem_req, o_dmem_we, i_dmem_ack;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
  logic [3:0]  o_dmem_be;
  logic        o_stall, o_pc_src, o_misalign;
  logic [31:0] o_branch_addr;
  logic        WB_reg_write, WB_mem_to_reg, WB_r31_ctrl;
  logic [31:0] WB_read_data, WB_alu_result, WB_pc;
  logic [4:0]  WB_selected_reg;

  always #5 i_clock = ~i_clock;

  mem_access_stage dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .MEM_reg_write(MEM_reg_write), .MEM_mem_to_reg(MEM_mem_to_reg), .MEM_mem_read(MEM_mem_read),
    .MEM_mem_write(MEM_mem_write), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
    .MEM_byte_en(MEM_byte_en), .MEM_halfword_en(MEM_halfword_en), .MEM_word_en(MEM_word_en),
    .MEM_r31_ctrl(MEM_r31_ctrl), .MEM_unsigned(MEM_unsigned), .MEM_branch_addr(MEM_branch_addr),
    .MEM_alu_result(MEM_alu_result), .MEM_data_a(MEM_data_a), .MEM_selected_reg(MEM_selected_reg),
    .MEM_pc(MEM_pc), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .o_pc_src(o_pc_src), .o_branch_addr(o_branch_addr),
    .WB_reg_write(WB_reg_write), .WB_mem_to_reg(WB_mem_to_reg), .WB_r31_ctrl(WB_r31_ctrl),
    .WB_read_data(WB_read_data), .WB_alu_result(WB_alu_result), .WB_selected_reg(WB_selected_reg),
    .WB_pc(WB_pc), .o_misalign(o_misalign)
  );

  typedef struct {
    logic        rw, m2r, rd, wr, br, zero, by_en, hw_en, wd_en, r31, uns, idle_ack;
    logic [31:0] baddr, alu, data, pc, rdata;
    logic [4:0]  sel;
    int          lat;
  } instr_t;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  // Expected values for the current cycle and the model's view of the MEM/WB register.
  logic        exp_stall, exp_req, exp_we, exp_pc_src, exp_wb_rw, exp_mis;
  logic [31:0] exp_addr, exp_wd, exp_br;
  logic [3:0]  exp_be;
  logic        wb_m2r, wb_r31, pend_rw, pend_mis;
  logic [31:0] wb_rd, wb_alu, wb_pc;
  logic [4:0]  wb_sel;

  int          stall_cnt, req_cnt, rw_cnt, mis_cnt;
  logic [31:0] snap_addr, snap_wdata, snap_wb_rd;
  logic [3:0]  snap_be;
  logic        snap_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // 0 = byte, 1 = half, 2 = word
  function automatic int m_size(input instr_t t);
    if (t.wd_en) return 2;
    if (t.hw_en) return 1;
    if (t.by_en) return 0;
    return 2;
  endfunction

  function automatic logic m_misaligned(input int sz, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 1 && a[0]) || (sz == 2 && a != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [1:0] a);
    if (sz == 0) return 4'(1 << int'(a));
    if (sz == 1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    if (sz == 0) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 1) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a, input int sz, input logic uns);
    logic [31:0] v;
    v = rd;
    if (sz == 0) begin
      v = (rd >> (int'(a) * 8)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic instr_t nop_instr();
    instr_t t;
    t = '{rw: 1'b0, m2r: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0, zero: 1'b0, by_en: 1'b0, hw_en: 1'b0,
          wd_en: 1'b0, r31: 1'b0, uns: 1'b0, idle_ack: 1'b0, baddr: 32'h0, alu: 32'h0, data: 32'h0,
          pc: 32'h0, rdata: 32'h0, sel: 5'd0, lat: 0};
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int op;
    op = $urandom_range(0, 9);
    t.rd = (op >= 4 && op <= 6) || op == 9;
    t.wr = (op >= 7);
    t.rw = 1'($urandom); t.m2r = 1'($urandom); t.br = 1'($urandom); t.zero = 1'($urandom);
    t.by_en = 1'($urandom); t.hw_en = 1'($urandom); t.wd_en = 1'($urandom);
    t.r31 = 1'($urandom); t.uns = 1'($urandom); t.idle_ack = 1'($urandom);
    t.baddr = $urandom; t.alu = $urandom; t.data = $urandom; t.pc = $urandom; t.rdata = $urandom;
    t.sel = 5'($urandom);
    t.lat = $urandom_range(0, 4);
    return t;
  endfunction

  task automatic drive(input instr_t t);
    MEM_reg_write = t.rw; MEM_mem_to_reg = t.m2r; MEM_mem_read = t.rd; MEM_mem_write = t.wr;
    MEM_branch = t.br; MEM_zero = t.zero; MEM_byte_en = t.by_en; MEM_halfword_en = t.hw_en;
    MEM_word_en = t.wd_en; MEM_r31_ctrl = t.r31; MEM_unsigned = t.uns; MEM_branch_addr = t.baddr;
    MEM_alu_result = t.alu; MEM_data_a = t.data; MEM_selected_reg = t.sel; MEM_pc = t.pc;
  endtask

  // Holds one instruction in MEM for as long as the pipeline would be frozen, then retires it into the model.
  task automatic run_instr(input instr_t t);
    int   sz, ncyc;
    logic mem, ld, trap;
    logic [1:0] a;
    a    = t.alu[1:0];
    sz   = m_size(t);
    mem  = t.rd | t.wr;
    ld   = t.rd & ~t.wr;
    trap = mem & m_misaligned(sz, a);
    ncyc = (mem && !trap) ? t.lat + 2 : 1;
    drive(t);
    exp_pc_src = t.br & t.zero;
    exp_br     = t.baddr;
    exp_addr   = t.alu & ~32'd3;
    exp_we     = t.wr;
    exp_be     = m_be(sz, a);
    exp_wd     = m_wdata(sz, t.data);
    for (int k = 0; k < ncyc; k++) begin
      if (mem && !trap) begin
        exp_stall    = (k <= t.lat);
        exp_req      = (k >= 1);
        i_dmem_ack   = (k == 0) ? t.idle_ack : (k == t.lat + 1);
        i_dmem_rdata = (k == t.lat + 1) ? t.rdata : $urandom;
      end else begin
        exp_stall    = 1'b0;
        exp_req      = 1'b0;
        i_dmem_ack   = t.idle_ack;
        i_dmem_rdata = $urandom;
      end
      exp_wb_rw = (k == 0) ? pend_rw : 1'b0;
      exp_mis   = (k == 0) ? pend_mis : 1'b0;
      @(posedge i_clock); #1;
    end
    wb_m2r   = t.m2r; wb_r31 = t.r31; wb_alu = t.alu; wb_sel = t.sel; wb_pc = t.pc;
    wb_rd    = (ld && !trap) ? m_load(t.rdata, a, sz, t.uns) : 32'h0;
    pend_rw  = t.rw & ~trap;
    pend_mis = trap;
  endtask

  task automatic reset_model();
    wb_m2r = 1'b0; wb_r31 = 1'b0; wb_rd = 32'h0; wb_alu = 32'h0; wb_sel = 5'd0; wb_pc = 32'h0;
    pend_rw = 1'b0; pend_mis = 1'b0;
  endtask

  task automatic reset_cnt();
    stall_cnt = 0; req_cnt = 0; rw_cnt = 0; mis_cnt = 0;
  endtask

  always @(negedge i_clock) begin
    if (chk_en) begin
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("pc_src", 32'(o_pc_src), 32'(exp_pc_src));
      chk("branch_addr", o_branch_addr, exp_br);
      chk("req", 32'(o_dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("addr", o_dmem_addr, exp_addr);
        chk("we", 32'(o_dmem_we), 32'(exp_we));
        if (exp_we) begin
          chk("be", 32'(o_dmem_be), 32'(exp_be));
          chk("wdata", o_dmem_wdata, exp_wd);
        end
      end
      chk("wb_reg_write", 32'(WB_reg_write), 32'(exp_wb_rw));
      chk("wb_mem_to_reg", 32'(WB_mem_to_reg), 32'(wb_m2r));
      chk("wb_r31", 32'(WB_r31_ctrl), 32'(wb_r31));
      chk("wb_read_data", WB_read_data, wb_rd);
      chk("wb_alu", WB_alu_result, wb_alu);
      chk("wb_sel", 32'(WB_selected_reg), 32'(wb_sel));
      chk("wb_pc", WB_pc, wb_pc);
      chk("misalign", 32'(o_misalign), 32'(exp_mis));
      if (o_stall) stall_cnt++;
      if (o_misalign) mis_cnt++;
      if (o_dmem_req) begin
        req_cnt++;
        snap_addr = o_dmem_addr; snap_be = o_dmem_be; snap_wdata = o_dmem_wdata; snap_we = o_dmem_we;
      end
      if (WB_reg_write) begin
        rw_cnt++;
        snap_wb_rd = WB_read_data;
      end
    end
  end

  initial begin
    instr_t t;
    reset_model();
    reset_cnt();
    drive(nop_instr());
    i_dmem_ack = 1'b0;
    i_dmem_rdata = 32'h0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_req", 32'(o_dmem_req), 32'h0);
    chk("rst_we", 32'(o_dmem_we), 32'h0);
    chk("rst_addr", o_dmem_addr, 32'h0);
    chk("rst_be", 32'(o_dmem_be), 32'h0);
    chk("rst_wdata", o_dmem_wdata, 32'h0);
    chk("rst_wb_rw", 32'(WB_reg_write), 32'h0);
    chk("rst_wb_rd", WB_read_data, 32'h0);
    chk("rst_misalign", 32'(o_misalign), 32'h0);
    i_reset = 1'b1;
    chk_en = 1'b1;
    run_instr(nop_instr());

    // sb 0x13
    t = nop_instr(); t.wr = 1'b1; t.by_en = 1'b1; t.alu = 32'h13; t.data = 32'h0000_00A5; t.lat = 1;
    reset_cnt();
    run_instr(t);
    chk("sb_be", 32'(snap_be), 32'h8);
    chk("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(snap_we), 32'h1);

    // lw 0x10, three wait cycles before ack
    t = nop_instr(); t.rd = 1'b1; t.rw = 1'b1; t.m2r = 1'b1; t.wd_en = 1'b1; t.alu = 32'h10;
    t.lat = 3; t.rdata = 32'hDEAD_BEEF; t.sel = 5'd7;
    reset_cnt();
    run_instr(t);
    run_instr(nop_instr());
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_wb_pulses", 32'(rw_cnt), 32'd1);
    chk("lw_read_data", snap_wb_rd, 32'hDEAD_BEEF);
    chk("lw_addr", snap_addr, 32'h10);

    // lh / lhu 0x22
    t = nop_instr(); t.rd = 1'b1; t.rw = 1'b1; t.hw_en = 1'b1; t.alu = 32'h22; t.rdata = 32'h8001_1234;
    run_instr(t);
    run_instr(nop_instr());
    chk("lh_read_data", snap_wb_rd, 32'hFFFF_8001);
    t.uns = 1'b1; t.lat = 2;
    run_instr(t);
    run_instr(nop_instr());
    chk("lhu_read_data", snap_wb_rd, 32'h0000_8001);

    // beq taken
    t = nop_instr(); t.br = 1'b1; t.zero = 1'b1; t.baddr = 32'h40;
    reset_cnt();
    run_instr(t);
    chk("beq_pc_src", 32'(o_pc_src), 32'h1);
    chk("beq_branch_addr", o_branch_addr, 32'h40);
    chk("beq_no_stall", 32'(stall_cnt), 32'd0);

    // lw at misaligned 0x11
    t = nop_instr(); t.rd = 1'b1; t.rw = 1'b1; t.wd_en = 1'b1; t.alu = 32'h11; t.rdata = 32'h1234_5678;
    reset_cnt();
    run_instr(t);
    run_instr(nop_instr());
`ifdef MEM_MISALIGN_TRAP_EN
    chk("trap_no_req", 32'(req_cnt), 32'd0);
    chk("trap_pulse", 32'(mis_cnt), 32'd1);
    chk("trap_no_wb", 32'(rw_cnt), 32'd0);
`else
    chk("mis_req_cycles", 32'(req_cnt), 32'd1);
    chk("mis_addr", snap_addr, 32'h10);
    chk("mis_no_pulse", 32'(mis_cnt), 32'd0);
`endif

    repeat (400) run_instr(rand_instr());

    // Reset while a load sits in WAIT, with a late ack afterwards.
    t = nop_instr(); t.rw = 1'b1; t.m2r = 1'b1; t.r31 = 1'b1; t.alu = 32'h55; t.pc = 32'h100; t.sel = 5'd3;
    run_instr(t);
    chk_en = 1'b0;
    t = nop_instr(); t.rd = 1'b1; t.rw = 1'b1; t.alu = 32'h40; t.pc = 32'h1234;
    drive(t);
    i_dmem_ack = 1'b0;
    @(posedge i_clock); #1;
    @(posedge i_clock); #1;
    chk("wait_req", 32'(o_dmem_req), 32'h1);
    chk("wait_stall", 32'(o_stall), 32'h1);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_req", 32'(o_dmem_req), 32'h0);
    chk("arst_stall", 32'(o_stall), 32'h0);
    chk("arst_wb_rw", 32'(WB_reg_write), 32'h0);
    chk("arst_wb_m2r", 32'(WB_mem_to_reg), 32'h0);
    chk("arst_wb_r31", 32'(WB_r31_ctrl), 32'h0);
    chk("arst_wb_alu", WB_alu_result, 32'h0);
    chk("arst_wb_sel", 32'(WB_selected_reg), 32'h0);
    chk("arst_wb_pc", WB_pc, 32'h0);
    i_dmem_ack = 1'b1;
    @(posedge i_clock); #1;
    chk("arst_hold_req", 32'(o_dmem_req), 32'h0);
    drive(nop_instr());
    i_reset = 1'b1;
    reset_model();
    chk_en = 1'b1;
    t = nop_instr(); t.idle_ack = 1'b1;
    run_instr(t);
    repeat (40) run_instr(rand_instr());
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
